// File: rtl/change_dispenser.sv
// Change payout engine: pays an amount greedily (10, 5, 1) through a req/ack hopper handshake,
// tracks per-denomination stock. Define CHANGE_LOG_EN to add coin and payout total counters.
module change_dispenser #(
  parameter int unsigned AMT_W          = 8,
  parameter int unsigned STOCK_W        = 8,
  parameter int unsigned INIT_STOCK     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               change_valid,
  input  logic [AMT_W-1:0]   change_amount,
  input  logic               coin_ack,
  input  logic               refill_valid,
  input  logic [3:0]         refill_code,
  input  logic [STOCK_W-1:0] refill_count,
  input  logic               clear_alarm,
  output logic               coin_req,
  output logic [3:0]         coin_code,
  output logic               busy,
  output logic               done,
  output logic               short_alarm,
  output logic [AMT_W-1:0]   remaining_out,
`ifdef CHANGE_LOG_EN
  output logic [15:0]        coins_out_total,
  output logic [15:0]        payouts_total,
`endif
  output logic [STOCK_W-1:0] stock_1,
  output logic [STOCK_W-1:0] stock_5,
  output logic [STOCK_W-1:0] stock_10
);

  localparam int unsigned TMR_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned SUM_W    = STOCK_W + 1;
  localparam int unsigned N_DENOM  = 3;
  localparam logic [STOCK_W-1:0] STOCK_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE, S_SELECT, S_REQ, S_RELEASE, S_DONE, S_FAULT
  } state_e;

  state_e             state_q, state_d;
  logic               coin_req_q, coin_req_d;
  logic [3:0]         coin_code_q, coin_code_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               alarm_q, alarm_d;
  logic [AMT_W-1:0]   remaining_q, remaining_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [STOCK_W-1:0] stock_q [N_DENOM];
  logic [STOCK_W-1:0] stock_d [N_DENOM];
  logic [STOCK_W-1:0] refill_add [N_DENOM];
  logic [SUM_W-1:0]   stock_sum [N_DENOM];
  logic [N_DENOM-1:0] dec;
  logic               acked;
  logic               done_entry;

  // Face value of a coin code; index 0/1/2 of the stock array holds 1/5/10.
  function automatic logic [AMT_W-1:0] coin_value(input logic [3:0] code);
    case (code)
      4'd1:    coin_value = AMT_W'(1);
      4'd2:    coin_value = AMT_W'(5);
      4'd3:    coin_value = AMT_W'(10);
      default: coin_value = '0;
    endcase
  endfunction

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    coin_req_d  = coin_req_q;
    coin_code_d = coin_code_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    alarm_d     = alarm_q;
    remaining_d = remaining_q;
    timer_d     = timer_q;
    dec         = '0;
    acked       = 1'b0;
    done_entry  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (change_valid) begin
          if (change_amount != '0) begin
            remaining_d = change_amount;
            busy_d      = 1'b1;
            state_d     = S_SELECT;
          end else begin
            remaining_d = '0;
            busy_d      = 1'b0;
            done_d      = 1'b1;
            done_entry  = 1'b1;
            state_d     = S_DONE;
          end
        end
      end

      S_SELECT: begin
        if (remaining_q == '0) begin
          busy_d     = 1'b0;
          done_d     = 1'b1;
          done_entry = 1'b1;
          state_d    = S_DONE;
        end else begin
          // Greedy pick, skipping denominations that are out of stock
          if (remaining_q >= AMT_W'(10) && stock_q[2] != '0) begin
            coin_code_d = 4'd3;
          end else if (remaining_q >= AMT_W'(5) && stock_q[1] != '0) begin
            coin_code_d = 4'd2;
          end else if (stock_q[0] != '0) begin
            coin_code_d = 4'd1;
          end else begin
            coin_code_d = 4'd0;
          end

          if (coin_code_d != 4'd0) begin
            coin_req_d = 1'b1;
            timer_d    = '0;
            state_d    = S_REQ;
          end else begin
            coin_req_d = 1'b0;
            busy_d     = 1'b0;
            alarm_d    = 1'b1;
            state_d    = S_FAULT;
          end
        end
      end

      S_REQ: begin
        if (coin_ack) begin
          remaining_d = remaining_q - coin_value(coin_code_q);
          case (coin_code_q)
            4'd1:    dec = 3'b001;
            4'd2:    dec = 3'b010;
            4'd3:    dec = 3'b100;
            default: dec = 3'b000;
          endcase
          acked       = 1'b1;
          coin_req_d  = 1'b0;
          coin_code_d = 4'd0;
          state_d     = S_RELEASE;
        end else if (timer_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
          coin_req_d  = 1'b0;
          coin_code_d = 4'd0;
          busy_d      = 1'b0;
          alarm_d     = 1'b1;
          state_d     = S_FAULT;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end

      S_RELEASE: begin
        if (!coin_ack) state_d = S_SELECT;
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      S_FAULT: begin
        if (clear_alarm) begin
          alarm_d = 1'b0;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Stock update: refill and payout decrement combine, then saturate
  always_comb begin
    for (int i = 0; i < N_DENOM; i++) begin
      refill_add[i] = (refill_valid && refill_code == 4'(i + 1)) ? refill_count : '0;
      stock_sum[i]  = {1'b0, stock_q[i]} + {1'b0, refill_add[i]} - SUM_W'(dec[i]);
      stock_d[i]    = stock_sum[i][STOCK_W] ? STOCK_MAX : stock_sum[i][STOCK_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      coin_req_q  <= 1'b0;
      coin_code_q <= 4'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      alarm_q     <= 1'b0;
      remaining_q <= '0;
      timer_q     <= '0;
      for (int i = 0; i < N_DENOM; i++) stock_q[i] <= STOCK_W'(INIT_STOCK);
    end else begin
      state_q     <= state_d;
      coin_req_q  <= coin_req_d;
      coin_code_q <= coin_code_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      alarm_q     <= alarm_d;
      remaining_q <= remaining_d;
      timer_q     <= timer_d;
      for (int i = 0; i < N_DENOM; i++) stock_q[i] <= stock_d[i];
    end
  end

`ifdef CHANGE_LOG_EN
  logic [15:0] coins_total_q, coins_total_d;
  logic [15:0] payouts_total_q, payouts_total_d;

  // Saturating activity counters
  always_comb begin
    coins_total_d   = coins_total_q;
    payouts_total_d = payouts_total_q;
    if (acked && coins_total_q != 16'hFFFF) coins_total_d = coins_total_q + 16'd1;
    if (done_entry && payouts_total_q != 16'hFFFF) payouts_total_d = payouts_total_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      coins_total_q   <= '0;
      payouts_total_q <= '0;
    end else begin
      coins_total_q   <= coins_total_d;
      payouts_total_q <= payouts_total_d;
    end
  end

  assign coins_out_total = coins_total_q;
  assign payouts_total   = payouts_total_q;
`endif

  assign coin_req      = coin_req_q;
  assign coin_code     = coin_code_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign short_alarm   = alarm_q;
  assign remaining_out = remaining_q;
  assign stock_1       = stock_q[0];
  assign stock_5       = stock_q[1];
  assign stock_10      = stock_q[2];

endmodule
